// File: rtl/delay_generator_prog.sv
// rtl/delay_generator_prog.sv - programmable fixed/random ms delay timer for the reaction-timer datapath
// Times from a start rising edge to expiry; the target comes from FIXED_MS or an LFSR-derived value in [MIN_MS, MAX_MS].
module delay_generator_prog #(
  parameter int          CNT_W     = 14,
  parameter int          FIXED_MS  = 1500,
  parameter int          MIN_MS    = 1000,
  parameter int          MAX_MS    = 4000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter bit          RETRIGGER = 1'b0
) (
  input  logic             clk_1ms,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic             done_pulse,
  output logic [CNT_W-1:0] target_ms,
  output logic [CNT_W-1:0] elapsed_ms
);

  typedef enum logic [1:0] {ST_IDLE, ST_COUNT, ST_DONE} state_t;

  localparam int unsigned SPAN   = MAX_MS - MIN_MS;
  localparam int unsigned MASK_K = $clog2(SPAN + 1);
  localparam logic [31:0] MASK   = (32'd1 << MASK_K) - 32'd1;
  localparam logic [CNT_W-1:0] FIXED_T = CNT_W'(FIXED_MS);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             start_q, start_d;
  logic             armed_q, armed_d;
  logic             pulse_q, pulse_d;
  logic             launch;
  logic [31:0]      rand_r;
  logic [CNT_W-1:0] rand_target;
  logic [CNT_W-1:0] load_target;

  always_ff @(posedge clk_1ms or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      target_q <= '0;
      lfsr_q   <= LFSR_SEED;
      start_q  <= 1'b0;
      armed_q  <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      target_q <= target_d;
      lfsr_q   <= lfsr_d;
      start_q  <= start_d;
      armed_q  <= armed_d;
      pulse_q  <= pulse_d;
    end
  end

  // Fold the masked LFSR value back into [0, SPAN] so every target stays in range.
  always_comb begin
    rand_r = {16'd0, lfsr_q} & MASK;
    if (rand_r > SPAN) begin
      rand_r = rand_r - (SPAN + 32'd1);
    end
    rand_target = CNT_W'(32'(MIN_MS) + rand_r);
  end

  always_comb begin
    start_d     = start;
    // A start level already high out of reset must drop once before it can launch.
    armed_d     = armed_q | ~start;
    launch      = start & ~start_q & armed_q;
    lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    load_target = mode ? rand_target : FIXED_T;
    state_d     = state_q;
    count_d     = count_q;
    target_d    = target_q;
    pulse_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!abort && launch) begin
          state_d  = ST_COUNT;
          count_d  = CNT_W'(1);
          target_d = load_target;
        end
      end
      ST_COUNT: begin
        if (abort) begin
          state_d  = ST_IDLE;
          count_d  = '0;
          target_d = '0;
        end else if (launch && RETRIGGER) begin
          count_d  = CNT_W'(1);
          target_d = load_target;
        end else if (count_q == target_q) begin
          state_d = ST_DONE;
          pulse_d = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (abort) begin
          state_d  = ST_IDLE;
          count_d  = '0;
          target_d = '0;
        end else if (launch) begin
          state_d  = ST_COUNT;
          count_d  = CNT_W'(1);
          target_d = load_target;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        count_d  = '0;
        target_d = '0;
      end
    endcase
  end

  assign busy       = (state_q == ST_COUNT);
  assign done       = (state_q == ST_DONE);
  assign done_pulse = pulse_q;
  assign target_ms  = target_q;
  assign elapsed_ms = count_q;

endmodule

// File: tb/tb_delay_generator_prog.sv
// tb/tb_delay_generator_prog.sv - self-checking bench for delay_generator_prog
// Three instances: defaults, RETRIGGER=1, and boundary parameters (MIN=MAX=1, FIXED=2^14-1).
module tb_delay_generator_prog;

  localparam int MIN_A = 1000;
  localparam int MAX_A = 4000;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk_1ms = 1'b0;
  logic reset;
  logic start_a, abort_a, mode_a, busy_a, done_a, pulse_a;
  logic start_b, abort_b, mode_b, busy_b, done_b, pulse_b;
  logic start_c, abort_c, mode_c, busy_c, done_c, pulse_c;
  logic [13:0] tgt_a, el_a, tgt_b, el_b, tgt_c, el_c;

  int errors = 0;
  int checks = 0;
  logic [15:0] m_lfsr;

  always #5 clk_1ms = ~clk_1ms;

  delay_generator_prog u_a (
    .clk_1ms(clk_1ms), .reset(reset), .start(start_a), .abort(abort_a), .mode(mode_a),
    .busy(busy_a), .done(done_a), .done_pulse(pulse_a), .target_ms(tgt_a), .elapsed_ms(el_a)
  );

  delay_generator_prog #(.RETRIGGER(1'b1)) u_b (
    .clk_1ms(clk_1ms), .reset(reset), .start(start_b), .abort(abort_b), .mode(mode_b),
    .busy(busy_b), .done(done_b), .done_pulse(pulse_b), .target_ms(tgt_b), .elapsed_ms(el_b)
  );

  delay_generator_prog #(.MIN_MS(1), .MAX_MS(1), .FIXED_MS(16383)) u_c (
    .clk_1ms(clk_1ms), .reset(reset), .start(start_c), .abort(abort_c), .mode(mode_c),
    .busy(busy_c), .done(done_c), .done_pulse(pulse_c), .target_ms(tgt_c), .elapsed_ms(el_c)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Reference LFSR: seeded on reset, one step per clock edge.
  always @(posedge clk_1ms or negedge reset) begin
    if (!reset) m_lfsr <= SEED;
    else        m_lfsr <= lfsr_step(m_lfsr);
  end

  function automatic int ref_target(input logic [15:0] l, input int lo, input int hi);
    int span, m, r;
    span = hi - lo;
    m = 0;
    while (m < span) m = m * 2 + 1;
    r = int'(l) & m;
    if (r > span) r = r - (span + 1);
    return lo + r;
  endfunction

  task automatic tick();
    @(posedge clk_1ms);
    @(negedge clk_1ms);
  endtask

  task automatic cleanup_all();
    start_a = 0; start_b = 0; start_c = 0;
    abort_a = 1; abort_b = 1; abort_c = 1;
    tick();
    abort_a = 0; abort_b = 0; abort_c = 0;
    tick();
  endtask

  task automatic test_reset();
    checks++;
    if ({busy_a, done_a, pulse_a, busy_b, done_b, pulse_b, busy_c, done_c, pulse_c} !== 9'd0) begin
      errors++;
      $display("FAIL reset_flags: got a=%b%b%b b=%b%b%b c=%b%b%b expected all 0",
               busy_a, done_a, pulse_a, busy_b, done_b, pulse_b, busy_c, done_c, pulse_c);
    end
    checks++;
    if ({tgt_a, el_a, tgt_b, el_b, tgt_c, el_c} !== 84'd0) begin
      errors++;
      $display("FAIL reset_counts: got tgt_a=%0d el_a=%0d tgt_c=%0d el_c=%0d expected 0", tgt_a, el_a, tgt_c, el_c);
    end
  endtask

  task automatic test_fixed();
    int n, bad;
    mode_a = 0; start_a = 1;
    tick();
    checks++;
    if (busy_a !== 1 || done_a !== 0 || el_a !== 14'd1 || tgt_a !== 14'd1500) begin
      errors++;
      $display("FAIL fixed_launch: got busy=%b done=%b el=%0d tgt=%0d expected 1 0 1 1500", busy_a, done_a, el_a, tgt_a);
    end
    n = 0; bad = 0;
    while (!done_a && n < 5000) begin
      tick(); n++;
      if (!done_a && (busy_a !== 1 || int'(el_a) != n + 1)) bad++;
    end
    checks++;
    if (n != 1500) begin errors++; $display("FAIL fixed_latency: got %0d expected 1500", n); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL fixed_count_track: got %0d bad cycles expected 0", bad); end
    checks++;
    if (pulse_a !== 1 || busy_a !== 0 || el_a !== 14'd1500) begin
      errors++;
      $display("FAIL fixed_expiry: got pulse=%b busy=%b el=%0d expected 1 0 1500", pulse_a, busy_a, el_a);
    end
    tick();
    checks++;
    if (pulse_a !== 0 || done_a !== 1) begin
      errors++;
      $display("FAIL fixed_pulse_width: got pulse=%b done=%b expected 0 1", pulse_a, done_a);
    end
    repeat (20) tick();
    checks++;
    if (done_a !== 1 || busy_a !== 0 || el_a !== 14'd1500) begin
      errors++;
      $display("FAIL fixed_no_relaunch: got done=%b busy=%b el=%0d expected 1 0 1500", done_a, busy_a, el_a);
    end
    cleanup_all();
  endtask

  task automatic test_random();
    bit seen[int];
    int exp_t, n;
    for (int i = 0; i < 64; i++) begin
      repeat ($urandom_range(0, 5)) tick();
      mode_a = 1; start_a = 1;
      exp_t = ref_target(m_lfsr, MIN_A, MAX_A);
      tick();
      mode_a = 0;
      checks++;
      if (int'(tgt_a) != exp_t) begin
        errors++;
        $display("FAIL random_target[%0d]: got %0d expected %0d", i, tgt_a, exp_t);
      end
      checks++;
      if (int'(tgt_a) < MIN_A || int'(tgt_a) > MAX_A) begin
        errors++;
        $display("FAIL random_range[%0d]: got %0d expected within [%0d,%0d]", i, tgt_a, MIN_A, MAX_A);
      end
      seen[int'(tgt_a)] = 1'b1;
      if (i < 6) begin
        n = 0;
        while (!done_a && n < 5000) begin tick(); n++; end
        checks++;
        if (n != exp_t) begin
          errors++;
          $display("FAIL random_latency[%0d]: got %0d expected %0d", i, n, exp_t);
        end
      end
      start_a = 0; abort_a = 1;
      tick();
      abort_a = 0;
    end
    checks++;
    if (seen.num() < 8) begin
      errors++;
      $display("FAIL random_distinct: got %0d distinct expected at least 8", seen.num());
    end
    cleanup_all();
  endtask

  task automatic test_abort();
    mode_a = 0; start_a = 1;
    tick();
    repeat (699) tick();
    checks++;
    if (el_a !== 14'd700) begin errors++; $display("FAIL abort_setup: got %0d expected 700", el_a); end
    abort_a = 1;
    tick();
    abort_a = 0;
    checks++;
    if (busy_a !== 0 || done_a !== 0 || pulse_a !== 0 || el_a !== 0 || tgt_a !== 0) begin
      errors++;
      $display("FAIL abort_clear: got busy=%b done=%b pulse=%b el=%0d tgt=%0d expected all 0",
               busy_a, done_a, pulse_a, el_a, tgt_a);
    end
    start_a = 0;
    tick();
    start_a = 1; abort_a = 1;
    tick();
    checks++;
    if (busy_a !== 0 || el_a !== 0) begin
      errors++;
      $display("FAIL abort_beats_launch: got busy=%b el=%0d expected 0 0", busy_a, el_a);
    end
    cleanup_all();
  endtask

  task automatic test_retrigger();
    int n, na, nb;
    mode_a = 0; mode_b = 0; start_a = 1; start_b = 1;
    tick();
    repeat (497) tick();
    start_a = 0; start_b = 0;
    tick();
    start_a = 1; start_b = 1;
    tick();
    checks++;
    if (el_a !== 14'd500) begin errors++; $display("FAIL retrig0_ignore: got %0d expected 500", el_a); end
    checks++;
    if (el_b !== 14'd1) begin errors++; $display("FAIL retrig1_reload: got %0d expected 1", el_b); end
    n = 0; na = -1; nb = -1;
    while ((na < 0 || nb < 0) && n < 4000) begin
      tick(); n++;
      if (done_a && na < 0) na = n;
      if (done_b && nb < 0) nb = n;
    end
    checks++;
    if (na != 1001) begin errors++; $display("FAIL retrig0_done: got %0d expected 1001", na); end
    checks++;
    if (nb != 1500) begin errors++; $display("FAIL retrig1_done: got %0d expected 1500", nb); end
    cleanup_all();
  endtask

  task automatic test_async_reset();
    mode_a = 0; start_a = 1;
    tick();
    repeat (100) tick();
    #2 reset = 0;
    #1;
    checks++;
    if (busy_a !== 0 || done_a !== 0 || pulse_a !== 0 || el_a !== 0 || tgt_a !== 0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b done=%b pulse=%b el=%0d tgt=%0d expected all 0",
               busy_a, done_a, pulse_a, el_a, tgt_a);
    end
    @(negedge clk_1ms);
    reset = 1;
    repeat (5) tick();
    checks++;
    if (busy_a !== 0) begin errors++; $display("FAIL held_start_no_launch: got busy=%b expected 0", busy_a); end
    start_a = 0;
    tick();
    start_a = 1;
    tick();
    checks++;
    if (busy_a !== 1 || el_a !== 14'd1) begin
      errors++;
      $display("FAIL relaunch_after_toggle: got busy=%b el=%0d expected 1 1", busy_a, el_a);
    end
    cleanup_all();
  endtask

  task automatic test_boundary_min();
    mode_c = 1; start_c = 1;
    tick();
    checks++;
    if (busy_c !== 1 || tgt_c !== 14'd1) begin
      errors++;
      $display("FAIL min_launch: got busy=%b tgt=%0d expected 1 1", busy_c, tgt_c);
    end
    tick();
    checks++;
    if (done_c !== 1 || pulse_c !== 1 || el_c !== 14'd1) begin
      errors++;
      $display("FAIL min_done: got done=%b pulse=%b el=%0d expected 1 1 1", done_c, pulse_c, el_c);
    end
    cleanup_all();
  endtask

  task automatic test_boundary_max();
    int n, bad;
    mode_c = 0; start_c = 1;
    tick();
    checks++;
    if (tgt_c !== 14'd16383) begin errors++; $display("FAIL max_target: got %0d expected 16383", tgt_c); end
    n = 0; bad = 0;
    while (!done_c && n < 20000) begin
      tick(); n++;
      if (!done_c && int'(el_c) != n + 1) bad++;
    end
    checks++;
    if (n != 16383 || bad != 0) begin
      errors++;
      $display("FAIL max_latency: got %0d (bad=%0d) expected 16383 (bad=0)", n, bad);
    end
    repeat (3) tick();
    checks++;
    if (el_c !== 14'd16383 || done_c !== 1) begin
      errors++;
      $display("FAIL max_no_wrap: got el=%0d done=%b expected 16383 1", el_c, done_c);
    end
    cleanup_all();
  endtask

  initial begin
    reset = 0;
    start_a = 0; abort_a = 0; mode_a = 0;
    start_b = 0; abort_b = 0; mode_b = 0;
    start_c = 0; abort_c = 0; mode_c = 0;
    repeat (3) @(negedge clk_1ms);
    test_reset();
    reset = 1;
    tick();
    tick();
    test_fixed();
    test_random();
    test_abort();
    test_retrigger();
    test_async_reset();
    test_boundary_min();
    test_boundary_max();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
